// File: rtl/sha1_pkg.sv
// sha1_pkg: widths and feeder state encoding shared by the
// SHA-1 block feeder and the compression core.
package sha1_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORDS_PER_BLOCK = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_SEND,
    S_HOLD
  } feeder_state_t;

endpackage

// File: rtl/sha1_block_feeder.sv
// sha1_block_feeder: pops 512-bit blocks from the UART rx FIFO and
// streams them to the SHA-1 core as 16 words, MS word first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_empty, r_data  FIFO status and read data
//   rd_uart           FIFO pop pulse
//   w_valid, w_data   word handshake towards the core
//   w_idx, w_ready    word index 0..15, core accept
//   blk_start         pulse with the first word of a block
//   blk_done          core finished compressing the block
//   busy, blk_count   activity flag, completed block count
module sha1_block_feeder
  import sha1_pkg::*;
#(
  parameter int DBIT     = BLOCK_W,
  parameter int WBIT     = WORD_W,
  parameter int FIFO_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  output logic            w_valid,
  output logic [WBIT-1:0] w_data,
  output logic [3:0]      w_idx,
  input  logic            w_ready,
  output logic            blk_start,
  input  logic            blk_done,
  output logic            busy,
  output logic [15:0]     blk_count
);

  localparam logic [3:0] LAST_IDX =
    4'(WORDS_PER_BLOCK - 1);

  feeder_state_t   state;
  logic [DBIT-1:0] shift_reg;
  logic [1:0]      wait_cnt;
  logic            done_seen;

  assign rd_uart = (state == S_POP);
  assign w_valid = (state == S_SEND);
  assign w_data  = shift_reg[DBIT-1 -: WBIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      wait_cnt  <= '0;
      w_idx     <= '0;
      blk_start <= 1'b0;
      busy      <= 1'b0;
      blk_count <= '0;
      done_seen <= 1'b0;
    end else begin
      blk_start <= 1'b0;

      // An early done (core finishing while words
      // are still in flight) must not be lost.
      if (blk_done && state != S_IDLE)
        done_seen <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (!rx_empty) begin
            state <= S_POP;
            busy  <= 1'b1;
          end
        end

        S_POP: begin
          state    <= S_WAIT;
          wait_cnt <= 2'(FIFO_LAT);
        end

        // r_data is valid in the last WAIT cycle.
        S_WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            shift_reg <= r_data;
            w_idx     <= '0;
            blk_start <= 1'b1;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (w_ready) begin
            shift_reg <= shift_reg << WBIT;
            w_idx     <= w_idx + 4'd1;
            if (w_idx == LAST_IDX)
              state <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (done_seen) begin
            done_seen <= 1'b0;
            blk_count <= blk_count + 16'd1;
            if (!rx_empty) begin
              state <= S_POP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_feeder.sv
// tb_sha1_block_feeder: FIFO model, word scoreboard and
// directed scenarios for sha1_block_feeder (LAT 1 and 3).
module tb_sha1_block_feeder;

  localparam int LAT = 1;
  localparam logic [511:0] GARBAGE = {16{32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rx_empty;
  logic [511:0] r_data;
  logic         rd_uart;
  logic         w_valid;
  logic [31:0]  w_data;
  logic [3:0]   w_idx;
  logic         w_ready;
  logic         blk_start;
  logic         blk_done;
  logic         busy;
  logic [15:0]  blk_count;

  logic         rx_empty3;
  logic [511:0] r_data3;
  logic         rd_uart3;
  logic         w_valid3;
  logic [31:0]  w_data3;
  logic [3:0]   w_idx3;
  logic         w_ready3;
  logic         blk_start3;
  logic         blk_done3;
  logic         busy3;
  logic [15:0]  blk_count3;

  sha1_block_feeder #(
    .DBIT(512), .WBIT(32), .FIFO_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .w_valid(w_valid),
    .w_data(w_data), .w_idx(w_idx),
    .w_ready(w_ready), .blk_start(blk_start),
    .blk_done(blk_done), .busy(busy),
    .blk_count(blk_count)
  );

  sha1_block_feeder #(
    .DBIT(512), .WBIT(32), .FIFO_LAT(3)
  ) dut3 (
    .clk(clk), .rst(rst),
    .rx_empty(rx_empty3), .r_data(r_data3),
    .rd_uart(rd_uart3), .w_valid(w_valid3),
    .w_data(w_data3), .w_idx(w_idx3),
    .w_ready(w_ready3), .blk_start(blk_start3),
    .blk_done(blk_done3), .busy(busy3),
    .blk_count(blk_count3)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int pcyc   = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_block(
    input logic [7:0] seed, input logic [7:0] step);
    logic [511:0] b;
    for (int i = 0; i < 64; i++)
      b[511-8*i -: 8] = seed + step * 8'(i);
    return b;
  endfunction

  // FIFO model: pop takes effect at the edge, data is
  // present only in the cycle LAT after the pop.
  logic [511:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [511:0] pend = GARBAGE;
  int age = 0;

  assign rx_empty = (rd_ptr == wr_ptr);
  assign r_data   = (age == LAT) ? pend : GARBAGE;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
      age    <= 0;
    end else if (rd_uart) begin
      pend   <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      age    <= 1;
    end else if (age != 0 && age < 7) begin
      age <= age + 1;
    end
  end

  logic [511:0] blk3;
  int age3 = 0;
  assign r_data3 = (age3 == 3) ? blk3 : GARBAGE;

  always @(posedge clk) begin
    if (rst) age3 <= 0;
    else if (rd_uart3) age3 <= 1;
    else if (age3 != 0 && age3 < 7) age3 <= age3 + 1;
  end

  // Scoreboard: every popped block becomes 16 expected
  // words; each accepted word must match in order.
  logic [31:0] exp_words[$];
  logic [31:0] log_words[$];
  int exp_idx      = 0;
  int pops         = 0;
  int dones        = 0;
  int pop_cyc      = 0;
  int total_pops   = 0;
  int last_pop_cyc = -1;
  int stalls       = 0;
  bit start_due    = 1'b0;

  always @(negedge clk) begin : scoreboard
    bit exp_start;
    if (rst) begin
      exp_words.delete();
      exp_idx   = 0;
      pops      = 0;
      dones     = 0;
      start_due = 1'b0;
    end else begin
      exp_start = start_due &&
                  (pcyc == pop_cyc + LAT + 1);
      chk("blk_start", blk_start, exp_start);
      if (exp_start) begin
        chk("first_valid", w_valid, 1);
        start_due = 1'b0;
      end
      if (busy && blk_done) dones++;
      if (rd_uart) begin
        chk("pop_nonempty", rx_empty, 0);
        chk("pop_after_done", dones >= pops, 1);
        for (int k = 0; k < 16; k++)
          exp_words.push_back(mem[rd_ptr][511-32*k -: 32]);
        pops++;
        total_pops++;
        pop_cyc      = pcyc;
        last_pop_cyc = pcyc;
        start_due    = 1'b1;
      end
      if (exp_idx != 0) chk("valid_held", w_valid, 1);
      if (w_valid) begin
        if (exp_words.size() == 0) begin
          chk("spurious_valid", w_valid, 0);
        end else begin
          chk("w_data", w_data, exp_words[0]);
          chk("w_idx", w_idx, exp_idx);
          if (w_ready) begin
            log_words.push_back(w_data);
            void'(exp_words.pop_front());
            exp_idx = (exp_idx + 1) % 16;
          end else begin
            stalls++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [511:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic give_done();
    blk_done = 1'b1;
    tick(1);
    blk_done = 1'b0;
  endtask

  task automatic wait_word(input int idx);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (w_valid && w_idx == idx) hit = 1'b1;
    end
    chk($sformatf("reach_idx%0d", idx), hit, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int p0;
    int c15;
    int p3;
    int v3;
    bit hit;
    logic [511:0] b;

    rst       = 1'b1;
    w_ready   = 1'b1;
    blk_done  = 1'b0;
    rx_empty3 = 1'b1;
    w_ready3  = 1'b1;
    blk_done3 = 1'b0;
    blk3      = mk_block(8'hF0, 8'h01);

    // Reset state
    tick(4);
    chk("rst_rd_uart", rd_uart, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_w_idx", w_idx, 0);
    chk("rst_blk_start", blk_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_count", blk_count, 0);
    rst = 1'b0;

    // blk_done in IDLE must not pre-arm HOLD
    give_done();
    tick(2);

    // Single block
    base = log_words.size();
    p0   = total_pops;
    push(mk_block(8'h00, 8'h01));
    wait_word(15);
    tick(5);
    chk("idle_done_ignored", blk_count, 0);
    chk("hold_busy", busy, 1);
    give_done();
    tick(2);
    chk("single_count", blk_count, 1);
    chk("single_pops", total_pops - p0, 1);
    chk("single_words", log_words.size() - base, 16);
    chk("single_w0", log_words[base], 32'h00010203);
    chk("single_w1", log_words[base+1], 32'h04050607);
    chk("single_w15", log_words[base+15], 32'h3C3D3E3F);
    chk("single_idle", busy, 0);

    // Backpressure 1,0,0,1
    base = log_words.size();
    p0   = stalls;
    push(mk_block(8'h11, 8'h07));
    for (int k = 0; k < 300 &&
         (log_words.size() - base) < 16; k++) begin
      w_ready = (k % 4 == 0) || (k % 4 == 3);
      tick(1);
    end
    w_ready = 1'b1;
    chk("bp_words", log_words.size() - base, 16);
    chk("bp_stalled", (stalls - p0) > 8, 1);
    chk("bp_w0", log_words[base], 32'h11181F26);
    give_done();
    tick(2);
    chk("bp_count", blk_count, 2);

    // Early done, next block already queued
    push(mk_block(8'h40, 8'h03));
    push(mk_block(8'h80, 8'h05));
    wait_word(8);
    tick(1);
    give_done();
    wait_word(15);
    c15 = pcyc;
    tick(4);
    chk("early_pop_cycle", last_pop_cyc, c15 + 2);
    chk("early_count", blk_count, 3);
    wait_word(15);
    tick(1);
    give_done();
    tick(2);
    chk("early_next_count", blk_count, 4);
    chk("early_idle", busy, 0);

    // Empty FIFO
    p0 = total_pops;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      chk("empty_busy", busy, 0);
    end
    chk("empty_no_pop", total_pops - p0, 0);

    // Three back-to-back blocks
    push(mk_block(8'h01, 8'h11));
    push(mk_block(8'h02, 8'h13));
    push(mk_block(8'h03, 8'h17));
    for (int n = 0; n < 3; n++) begin
      wait_word(15);
      tick(3);
      give_done();
    end
    tick(3);
    chk("three_pops", total_pops - p0, 3);
    chk("three_count", blk_count, 7);
    chk("three_idle", busy, 0);

    // Reset while sending word 6
    push(mk_block(8'hC0, 8'h01));
    wait_word(5);
    @(posedge clk);
    #1;
    chk("pre_rst_idx", w_idx, 6);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_w_valid", w_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", blk_count, 0);
    chk("mid_rst_w_idx", w_idx, 0);
    rst = 1'b0;
    tick(1);
    base = log_words.size();
    push(mk_block(8'h5A, 8'h09));
    wait_word(15);
    tick(1);
    give_done();
    tick(2);
    chk("post_rst_count", blk_count, 1);
    chk("post_rst_w0", log_words[base], 32'h5A636C75);
    chk("post_rst_words", log_words.size() - base, 16);

    // FIFO_LAT=3 instance
    rx_empty3 = 1'b0;
    hit = 1'b0;
    p3  = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      if (rd_uart3) begin
        hit = 1'b1;
        p3  = pcyc;
      end
    end
    chk("lat3_pop_seen", hit, 1);
    @(posedge clk);
    #1;
    rx_empty3 = 1'b1;
    hit = 1'b0;
    v3  = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      if (w_valid3) begin
        hit = 1'b1;
        v3  = pcyc;
      end
    end
    chk("lat3_valid_seen", hit, 1);
    chk("lat3_delay", v3 - p3, 4);
    chk("lat3_blk_start", blk_start3, 1);
    chk("lat3_w0_literal", w_data3, 32'hF0F1F2F3);
    b = blk3;
    for (int j = 0; j < 16; j++) begin
      chk("lat3_w_data", w_data3, b[511-32*j -: 32]);
      chk("lat3_w_idx", w_idx3, j);
      if (j == 15)
        chk("lat3_w15_literal", w_data3, 32'h2C2D2E2F);
      else
        @(negedge clk);
    end
    @(posedge clk);
    #1;
    blk_done3 = 1'b1;
    tick(1);
    blk_done3 = 1'b0;
    tick(2);
    chk("lat3_count", blk_count3, 1);
    chk("lat3_idle", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
